axi_r_response_router: RTL and testbench



---
 rtl/axi_r_response_router_pkg.sv | 30 +++
 rtl/axi_r_skid_buffer.sv | 65 ++++++
 rtl/axi_r_response_router.sv | 138 +++++++++++++
 tb/tb_axi_r_response_router.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_r_response_router_pkg.sv
// ============================================================================
// Module      : axi_r_response_router_pkg
// Description : Shared types and width helpers for the AXI R response router.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_r_response_router_pkg;

    localparam int RESP_W = 2;

    typedef struct packed {
        logic [RESP_W-1:0] resp;
        logic              last;
    } r_ctl_t;

    localparam int CTL_W = $bits(r_ctl_t);

    // Counter must be able to hold MAX_OUTST itself, hence the +1.
    function automatic int cnt_width(input int max_outst);
        return $clog2(max_outst + 1);
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_r_skid_buffer.sv
// ============================================================================
// Module      : axi_r_skid_buffer
// Description : Two-entry FIFO skid buffer with a registered ready output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_r_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_pop
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wr_ptr;
    logic             r_rd_ptr;
    logic [1:0]       r_count;
    logic             r_ready;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_count_next;

    assign w_push       = in_valid && r_ready;
    assign w_pop        = out_pop && (r_count != 2'd0);
    assign w_count_next = r_count + 2'(w_push) - 2'(w_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            r_count <= w_count_next;
            // Ready looks ahead at next occupancy, so it never depends on out_pop combinationally.
            r_ready <= (w_count_next != 2'd2);
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    assign in_ready  = r_ready;
    assign out_valid = (r_count != 2'd0);
    assign out_data  = r_mem[r_rd_ptr];

endmodule

`default_nettype wire

// File: rtl/axi_r_response_router.sv
// ============================================================================
// Module      : axi_r_response_router
// Description : Routes AXI R beats to target ports by ID prefix and tracks
//               outstanding reads per port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_r_response_router
    import axi_r_response_router_pkg::*;
#(
    parameter int AXI_DATA_W  = 64,
    parameter int AXI_USER_W  = 6,
    parameter int N_TARG_PORT = 7,
    parameter int LOG_N_TARG  = idx_width(N_TARG_PORT),
    parameter int AXI_ID_IN   = 16,
    parameter int AXI_ID_OUT  = AXI_ID_IN + LOG_N_TARG,
    parameter int MAX_OUTST   = 8,
    localparam int CNT_W      = cnt_width(MAX_OUTST)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [AXI_ID_OUT-1:0]  rid_i,
    input  logic [AXI_DATA_W-1:0]  rdata_i,
    input  logic [RESP_W-1:0]      rresp_i,
    input  logic                   rlast_i,
    input  logic [AXI_USER_W-1:0]  ruser_i,
    input  logic                   rvalid_i,
    output logic                   rready_o,
    output logic [AXI_ID_IN-1:0]   rid_o      [N_TARG_PORT],
    output logic [AXI_DATA_W-1:0]  rdata_o    [N_TARG_PORT],
    output logic [RESP_W-1:0]      rresp_o    [N_TARG_PORT],
    output logic                   rlast_o    [N_TARG_PORT],
    output logic [AXI_USER_W-1:0]  ruser_o    [N_TARG_PORT],
    output logic [N_TARG_PORT-1:0] rvalid_o,
    input  logic [N_TARG_PORT-1:0] rready_i,
    input  logic                   ar_issue_i,
    input  logic [LOG_N_TARG-1:0]  ar_issue_port_i,
    output logic [CNT_W-1:0]       outst_cnt_o [N_TARG_PORT],
    output logic [N_TARG_PORT-1:0] ar_block_o,
    output logic                   err_o
);

    localparam int                  PAY_W      = AXI_ID_OUT + AXI_DATA_W + CTL_W + AXI_USER_W;
    localparam logic [CNT_W-1:0]    c_max      = CNT_W'(MAX_OUTST);
    localparam logic [LOG_N_TARG:0] c_n_port   = (LOG_N_TARG + 1)'(N_TARG_PORT);

    logic [PAY_W-1:0]       w_in_flat;
    logic [PAY_W-1:0]       w_head_flat;
    logic                   w_head_valid;
    logic [AXI_ID_OUT-1:0]  w_head_id;
    logic [AXI_DATA_W-1:0]  w_head_data;
    r_ctl_t                 w_head_ctl;
    logic [AXI_USER_W-1:0]  w_head_user;
    logic [LOG_N_TARG-1:0]  w_port;
    logic                   w_port_ok;
    logic                   w_sel_ready;
    logic                   w_pop;
    logic                   w_bad_pop;
    logic [N_TARG_PORT-1:0] w_cnt_err;
    logic                   r_err;

    assign w_in_flat = {rid_i, rdata_i, rresp_i, rlast_i, ruser_i};
    assign {w_head_id, w_head_data, w_head_ctl, w_head_user} = w_head_flat;

    axi_r_skid_buffer #(
        .WIDTH (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (rvalid_i),
        .in_data   (w_in_flat),
        .in_ready  (rready_o),
        .out_valid (w_head_valid),
        .out_data  (w_head_flat),
        .out_pop   (w_pop)
    );

    assign w_port    = w_head_id[AXI_ID_OUT-1:AXI_ID_IN];
    assign w_port_ok = ({1'b0, w_port} < c_n_port);

    always_comb begin
        w_sel_ready = 1'b0;
        for (int k = 0; k < N_TARG_PORT; k++) begin
            if (w_port == LOG_N_TARG'(k)) begin
                w_sel_ready = rready_i[k];
            end
        end
    end

    // Beats addressed to a nonexistent port are drained immediately so they cannot wedge the buffer.
    assign w_pop     = w_head_valid && (!w_port_ok || w_sel_ready);
    assign w_bad_pop = w_head_valid && !w_port_ok;

    for (genvar k = 0; k < N_TARG_PORT; k++) begin : g_port
        logic             w_inc;
        logic             w_dec;
        logic [CNT_W-1:0] r_cnt;

        assign w_inc = ar_issue_i && (ar_issue_port_i == LOG_N_TARG'(k));
        assign w_dec = w_pop && w_head_ctl.last && w_port_ok && (w_port == LOG_N_TARG'(k));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (w_inc && !w_dec && (r_cnt != c_max)) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (w_dec && !w_inc && (r_cnt != '0)) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end

        assign w_cnt_err[k] = (w_inc && !w_dec && (r_cnt == c_max)) ||
                              (w_dec && !w_inc && (r_cnt == '0));

        assign outst_cnt_o[k] = r_cnt;
        assign ar_block_o[k]  = (r_cnt == c_max);
        assign rvalid_o[k]    = w_head_valid && w_port_ok && (w_port == LOG_N_TARG'(k));
        assign rid_o[k]       = w_head_id[AXI_ID_IN-1:0];
        assign rdata_o[k]     = w_head_data;
        assign rresp_o[k]     = w_head_ctl.resp;
        assign rlast_o[k]     = w_head_ctl.last;
        assign ruser_o[k]     = w_head_user;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_bad_pop || (|w_cnt_err)) begin
            r_err <= 1'b1;
        end
    end

    assign err_o = r_err;

endmodule

`default_nettype wire

// File: tb/tb_axi_r_response_router.sv
// Directed bench for axi_r_response_router with default parameters (7 ports, 16-bit inner ID).
`default_nettype none

module tb_axi_r_response_router;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] rid_i;
    logic [63:0] rdata_i;
    logic [1:0]  rresp_i;
    logic        rlast_i;
    logic [5:0]  ruser_i;
    logic        rvalid_i;
    logic        rready_o;
    logic [15:0] rid_o    [7];
    logic [63:0] rdata_o  [7];
    logic [1:0]  rresp_o  [7];
    logic        rlast_o  [7];
    logic [5:0]  ruser_o  [7];
    logic [6:0]  rvalid_o;
    logic [6:0]  rready_i;
    logic        ar_issue_i;
    logic [2:0]  ar_issue_port_i;
    logic [3:0]  outst_cnt_o [7];
    logic [6:0]  ar_block_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    axi_r_response_router dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .rid_i           (rid_i),
        .rdata_i         (rdata_i),
        .rresp_i         (rresp_i),
        .rlast_i         (rlast_i),
        .ruser_i         (ruser_i),
        .rvalid_i        (rvalid_i),
        .rready_o        (rready_o),
        .rid_o           (rid_o),
        .rdata_o         (rdata_o),
        .rresp_o         (rresp_o),
        .rlast_o         (rlast_o),
        .ruser_o         (ruser_o),
        .rvalid_o        (rvalid_o),
        .rready_i        (rready_i),
        .ar_issue_i      (ar_issue_i),
        .ar_issue_port_i (ar_issue_port_i),
        .outst_cnt_o     (outst_cnt_o),
        .ar_block_o      (ar_block_o),
        .err_o           (err_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic [2:0] port, input logic [15:0] id,
                        input logic [63:0] data, input logic last);
        rid_i    = {port, id};
        rdata_i  = data;
        rresp_i  = port[1:0];
        ruser_i  = id[5:0];
        rlast_i  = last;
        rvalid_i = 1'b1;
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        rvalid_i   = 1'b0;
        ar_issue_i = 1'b0;
        rready_i   = 7'h7F;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic issue(input logic [2:0] port, input int n);
        for (int i = 0; i < n; i++) begin
            ar_issue_i      = 1'b1;
            ar_issue_port_i = port;
            tick();
        end
        ar_issue_i = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; rid_i = '0; rdata_i = '0; rresp_i = '0; rlast_i = 1'b0;
        ruser_i = '0; rvalid_i = 1'b0; rready_i = 7'h7F;
        ar_issue_i = 1'b0; ar_issue_port_i = '0;

        // Reset state
        tick();
        tick();
        chk("rst_rready", 64'(rready_o), 64'd0);
        chk("rst_rvalid", 64'(rvalid_o), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_cnt3", 64'(outst_cnt_o[3]), 64'd0);
        chk("rst_block", 64'(ar_block_o), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_rready", 64'(rready_o), 64'd1);

        // Single beat to port 2
        beat(3'd2, 16'h00A5, 64'h1111_2222_3333_4444, 1'b0);
        chk("lat_pre", 64'(rvalid_o), 64'd0);
        tick();
        rvalid_i = 1'b0;
        chk("p2_rvalid", 64'(rvalid_o), 64'h04);
        chk("p2_rid", 64'(rid_o[2]), 64'h00A5);
        chk("bcast_data", 64'(rdata_o[5]), 64'h1111_2222_3333_4444);
        chk("bcast_user", 64'(ruser_o[0]), 64'h25);
        chk("bcast_resp", 64'(rresp_o[2]), 64'd2);
        tick();
        chk("p2_drained", 64'(rvalid_o), 64'd0);

        // Back-to-back ports 0, 6, 0
        beat(3'd0, 16'h0010, 64'hA0, 1'b0);
        tick();
        chk("b2b_v0", 64'(rvalid_o), 64'h01);
        chk("b2b_d0", 64'(rdata_o[0]), 64'hA0);
        beat(3'd6, 16'h0011, 64'hB6, 1'b0);
        tick();
        chk("b2b_v1", 64'(rvalid_o), 64'h40);
        chk("b2b_d1", 64'(rdata_o[6]), 64'hB6);
        chk("b2b_rdy", 64'(rready_o), 64'd1);
        beat(3'd0, 16'h0012, 64'hC0, 1'b0);
        tick();
        rvalid_i = 1'b0;
        chk("b2b_v2", 64'(rvalid_o), 64'h01);
        chk("b2b_d2", 64'(rdata_o[0]), 64'hC0);
        tick();
        chk("b2b_end", 64'(rvalid_o), 64'd0);

        // 4-beat burst to port 1 with backpressure
        issue(3'd1, 1);
        chk("bu_cnt1", 64'(outst_cnt_o[1]), 64'd1);
        beat(3'd1, 16'h0020, 64'hD0, 1'b0);
        tick();
        chk("bu_d0", 64'(rdata_o[1]), 64'hD0);
        beat(3'd1, 16'h0020, 64'hD1, 1'b0);
        tick();
        chk("bu_d1", 64'(rdata_o[1]), 64'hD1);
        rready_i = 7'h7D;
        beat(3'd1, 16'h0020, 64'hD2, 1'b0);
        tick();
        chk("bu_full", 64'(rready_o), 64'd0);
        chk("bu_hold_v", 64'(rvalid_o), 64'h02);
        chk("bu_hold_d", 64'(rdata_o[1]), 64'hD1);
        beat(3'd1, 16'h0020, 64'hD3, 1'b1);
        tick();
        tick();
        chk("bu_stall_v", 64'(rvalid_o), 64'h02);
        chk("bu_stall_d", 64'(rdata_o[1]), 64'hD1);
        chk("bu_stall_r", 64'(rready_o), 64'd0);
        rready_i = 7'h7F;
        tick();
        chk("bu_d2", 64'(rdata_o[1]), 64'hD2);
        chk("bu_rdy_back", 64'(rready_o), 64'd1);
        tick();
        rvalid_i = 1'b0;
        chk("bu_d3", 64'(rdata_o[1]), 64'hD3);
        chk("bu_last", 64'(rlast_o[1]), 64'd1);
        tick();
        chk("bu_empty", 64'(rvalid_o), 64'd0);
        chk("bu_cnt1_0", 64'(outst_cnt_o[1]), 64'd0);
        chk("bu_err", 64'(err_o), 64'd0);

        // Outstanding limit on port 3
        issue(3'd3, 8);
        chk("ol_cnt8", 64'(outst_cnt_o[3]), 64'd8);
        chk("ol_block", 64'(ar_block_o), 64'h08);
        beat(3'd3, 16'h0030, 64'hE3, 1'b1);
        tick();
        rvalid_i = 1'b0;
        chk("ol_rvalid", 64'(rvalid_o), 64'h08);
        tick();
        chk("ol_cnt7", 64'(outst_cnt_o[3]), 64'd7);
        chk("ol_unblock", 64'(ar_block_o), 64'd0);

        // Simultaneous issue and rlast pop on port 4
        issue(3'd4, 2);
        beat(3'd4, 16'h0040, 64'hF4, 1'b1);
        tick();
        rvalid_i        = 1'b0;
        ar_issue_i      = 1'b1;
        ar_issue_port_i = 3'd4;
        tick();
        ar_issue_i = 1'b0;
        chk("sim_cnt4", 64'(outst_cnt_o[4]), 64'd2);
        chk("sim_err", 64'(err_o), 64'd0);

        // Reset while two beats are buffered
        rready_i = 7'h5F;
        beat(3'd5, 16'h0050, 64'h50, 1'b0);
        tick();
        beat(3'd5, 16'h0051, 64'h51, 1'b0);
        tick();
        rvalid_i = 1'b0;
        rst_n    = 1'b0;
        tick();
        chk("mr_rvalid", 64'(rvalid_o), 64'd0);
        chk("mr_rready", 64'(rready_o), 64'd0);
        chk("mr_cnt4", 64'(outst_cnt_o[4]), 64'd0);
        rst_n    = 1'b1;
        rready_i = 7'h7F;
        tick();
        chk("mr_rel_r", 64'(rready_o), 64'd1);
        tick();
        chk("mr_no_beat", 64'(rvalid_o), 64'd0);

        // rlast with zero outstanding
        beat(3'd0, 16'h0060, 64'h60, 1'b1);
        tick();
        rvalid_i = 1'b0;
        chk("uf_rvalid", 64'(rvalid_o), 64'h01);
        tick();
        chk("uf_err", 64'(err_o), 64'd1);
        chk("uf_cnt0", 64'(outst_cnt_o[0]), 64'd0);

        // Invalid port index drops the beat and sets sticky error
        do_reset();
        chk("ip_err_clr", 64'(err_o), 64'd0);
        beat(3'd7, 16'h0070, 64'h70, 1'b0);
        tick();
        rvalid_i = 1'b0;
        chk("ip_novalid", 64'(rvalid_o), 64'd0);
        tick();
        chk("ip_err", 64'(err_o), 64'd1);
        chk("ip_novalid2", 64'(rvalid_o), 64'd0);
        tick();
        tick();
        chk("ip_sticky", 64'(err_o), 64'd1);

        // Saturation at MAX_OUTST
        do_reset();
        issue(3'd2, 9);
        chk("sat_cnt", 64'(outst_cnt_o[2]), 64'd8);
        chk("sat_err", 64'(err_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
